// File: rtl/regbank_4x32_pkg.sv
// Shared sizing and operand types for datapath clients of the register bank.
package regbank_4x32_pkg;

  localparam int REG_WIDTH = 32;
  localparam int REG_DEPTH = 4;
  localparam int REG_AW    = $clog2(REG_DEPTH);

  typedef logic [REG_AW-1:0]    reg_addr_t;
  typedef logic [REG_WIDTH-1:0] reg_data_t;

  // Address arithmetic wraps modulo REG_DEPTH because the result keeps only REG_AW bits.
  function automatic reg_addr_t addr_inc(input reg_addr_t a);
    return a + reg_addr_t'(1);
  endfunction

endpackage

// File: rtl/regbank_4x32_read_mux.sv
// DEPTH:1 combinational read multiplexer; one instance serves one read port.
module regbank_read_mux #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] i_data,
  input  logic [AW-1:0]               i_sel,
  output logic [WIDTH-1:0]            o_data
);

  always_comb begin
    o_data = i_data[i_sel];
  end

endmodule

// File: rtl/regbank_4x32.sv
// Register file with one synchronous write port and two asynchronous read ports.
// Reads show the stored value only; there is no write-to-read bypass.
module regbank_4x32
  import regbank_4x32_pkg::*;
#(
  parameter  int WIDTH = REG_WIDTH,
  parameter  int DEPTH = REG_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write,
  input  logic [AW-1:0]    dr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    sr1,
  input  logic [AW-1:0]    sr2,
  output logic [WIDTH-1:0] rdData1,
  output logic [WIDTH-1:0] rdData2
);

  logic [WIDTH-1:0]            r_regs [DEPTH];
  logic [DEPTH-1:0][WIDTH-1:0] w_regs_pk;

  // Reset clears every register immediately and blocks any write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (write) begin
      r_regs[dr] <= wrData;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pack
    assign w_regs_pk[gi] = r_regs[gi];
  end

  regbank_read_mux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rd1 (
    .i_data (w_regs_pk),
    .i_sel  (sr1),
    .o_data (rdData1)
  );

  regbank_read_mux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rd2 (
    .i_data (w_regs_pk),
    .i_sel  (sr2),
    .o_data (rdData2)
  );

endmodule

// File: tb/tb_regbank_4x32.sv
// Scoreboard bench for regbank_4x32: expected read pairs are queued as addresses are driven.
module tb_regbank_4x32;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic [1:0]  dr;
  logic [31:0] wrData;
  logic [1:0]  sr1;
  logic [1:0]  sr2;
  logic [31:0] rdData1;
  logic [31:0] rdData2;

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] mdl [4];

  regbank_4x32 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .write   (write),
    .dr      (dr),
    .wrData  (wrData),
    .sr1     (sr1),
    .sr2     (sr2),
    .rdData1 (rdData1),
    .rdData2 (rdData2)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    dr     = a;
    wrData = d;
    write  = 1'b1;
    tick();
    write  = 1'b0;
  endtask

  task automatic read_pair(input logic [1:0] a, input logic [1:0] b,
                           input logic [31:0] e1, input logic [31:0] e2, input string tag);
    exp_t e;
    sr1 = a;
    sr2 = b;
    sb.push_back('{tag, e1, e2});
    #1;
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_val($sformatf("%s_p1[%0d]", e.tag, a), rdData1, e.e1);
      check_val($sformatf("%s_p2[%0d]", e.tag, b), rdData2, e.e2);
    end
  endtask

  initial begin
    logic [1:0]  a;
    logic [1:0]  b;
    logic [31:0] d;

    rst_n = 1'b0; write = 1'b0; dr = '0; wrData = '0; sr1 = '0; sr2 = '0;
    #1;
    read_pair(2'd0, 2'd1, 32'd0, 32'd0, "por");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Seed a distinct pattern, then clear it with an unclocked reset.
    for (int i = 0; i < 4; i++) write_reg(2'(i), 32'h1000_0000 + 32'(i) * 32'h11);
    for (int i = 0; i < 4; i++)
      read_pair(2'(i), 2'(3 - i), 32'h1000_0000 + 32'(i) * 32'h11,
                32'h1000_0000 + 32'(3 - i) * 32'h11, "seed");
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        read_pair(2'(i), 2'(j), 32'd0, 32'd0, "async_rst");
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) write_reg(2'(i), 32'(5 * i));
    read_pair(2'd0, 2'd1, 32'd0,  32'd5,  "seq");
    read_pair(2'd1, 2'd2, 32'd5,  32'd10, "seq");
    read_pair(2'd2, 2'd3, 32'd10, 32'd15, "seq");
    read_pair(2'd3, 2'd0, 32'd15, 32'd0,  "seq_wrap");

    write = 1'b0; dr = 2'd2; wrData = 32'hDEADBEEF;
    repeat (3) tick();
    read_pair(2'd2, 2'd2, 32'd10, 32'd10, "wr_dis");

    read_pair(2'd3, 2'd3, 32'd15, 32'd15, "same_addr");

    dr = 2'd1; wrData = 32'hA5A5A5A5; write = 1'b1;
    read_pair(2'd1, 2'd0, 32'd5, 32'd0, "rdw_before");
    tick();
    write = 1'b0;
    read_pair(2'd1, 2'd0, 32'hA5A5A5A5, 32'd0, "rdw_after");
    write_reg(2'd1, 32'd5);
    read_pair(2'd1, 2'd2, 32'd5, 32'd10, "restore");

    // Reset arrives mid-cycle while a write to register 2 is pending.
    tick();
    dr = 2'd2; wrData = 32'h12345678; write = 1'b1;
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) read_pair(2'(i), 2'(3 - i), 32'd0, 32'd0, "rst_mid");
    tick();
    read_pair(2'd2, 2'd1, 32'd0, 32'd0, "rst_hold");
    write = 1'b0;
    rst_n = 1'b1;
    tick();
    read_pair(2'd2, 2'd3, 32'd0, 32'd0, "rst_nowrite");
    write_reg(2'd3, 32'd77);
    read_pair(2'd3, 2'd2, 32'd77, 32'd0, "post_rst_wr");

    mdl[0] = 32'd0; mdl[1] = 32'd0; mdl[2] = 32'd0; mdl[3] = 32'd77;
    for (int n = 0; n < 24; n++) begin
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        write_reg(a, d);
        mdl[a] = d;
      end else begin
        dr = a; wrData = d; write = 1'b0;
        tick();
      end
      a = 2'($urandom_range(0, 3));
      b = 2'($urandom_range(0, 3));
      read_pair(a, b, mdl[a], mdl[b], "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
